// File: rtl/demux32_1_4_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : demux32_1_4_dispatch_pkg
// Brief   : Shared lane count, select width, mode encodings and lane index type
// Rev     : 1.0
// ============================================================================
package demux32_1_4_dispatch_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    typedef logic [SEL_W-1:0] lane_idx_t;

endpackage
`default_nettype wire

// File: rtl/demux32_1_4_dispatch_slot.sv
`default_nettype none
// ============================================================================
// Module  : demux32_1_4_dispatch_slot
// Brief   : Single-entry registered lane with valid/ready drain handshake
// Rev     : 1.0
// ============================================================================
module demux32_1_4_dispatch_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load wins over drain so a lane can be refilled in the cycle it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (r_valid && drain_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign free  = ~r_valid | drain_ready;

endmodule
`default_nettype wire

// File: rtl/demux32_1_4_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : demux32_1_4_dispatch
// Brief   : Registered 1-to-4 demux dispatcher, directed or round-robin steering
// Rev     : 1.0
// ============================================================================
module demux32_1_4_dispatch
    import demux32_1_4_dispatch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_mode,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [SEL_W-1:0]     rr_ptr,
    output logic                 busy
);

    lane_idx_t            r_rr_ptr;
    lane_idx_t            w_target;
    logic                 w_accept;
    logic [NUM_LANES-1:0] w_free;
    logic [NUM_LANES-1:0] w_valid;
    logic [WIDTH-1:0]     w_data [NUM_LANES];

    assign w_target = (in_mode == MODE_RR) ? r_rr_ptr : lane_idx_t'(in_sel);
    // Strict ordering: only the targeted lane's state matters, never in_valid.
    assign in_ready = ~rst & w_free[w_target];
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            demux32_1_4_dispatch_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .load        (w_accept && (w_target == lane_idx_t'(i))),
                .load_data   (in_data),
                .drain_ready (out_ready[i]),
                .valid       (w_valid[i]),
                .data        (w_data[i]),
                .free        (w_free[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept && (in_mode == MODE_RR)) begin
            r_rr_ptr <= r_rr_ptr + lane_idx_t'(1);
        end
    end

    assign out_valid = w_valid;
    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];
    assign rr_ptr    = r_rr_ptr;
    assign busy      = |w_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux32_1_4_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux32_1_4_dispatch
// Brief   : Directed self-checking bench for the 1-to-4 dispatcher
// Rev     : 1.0
// ============================================================================
module tb_demux32_1_4_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_mode;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic [1:0]  rr_ptr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    demux32_1_4_dispatch #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .rr_ptr    (rr_ptr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs are changed and outputs sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] lane_data(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
        in_mode = 1'b0; out_ready = 4'b0000;

        // Reset and idle
        tick(); tick();
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_data0", out_data0, 32'h0);
        chk("rst_data1", out_data1, 32'h0);
        chk("rst_data2", out_data2, 32'h0);
        chk("rst_data3", out_data3, 32'h0);
        chk("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed fill with no drain
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h11111111;
        tick();
        chk("dir_valid", {28'd0, out_valid}, 32'b0100);
        chk("dir_data2", out_data2, 32'h11111111);
        chk("dir_busy", {31'd0, busy}, 32'd1);
        in_data = 32'h22222222;
        #1;
        chk("dir_stall_ready", {31'd0, in_ready}, 32'd0);
        repeat (5) tick();
        chk("dir_hold_data2", out_data2, 32'h11111111);
        chk("dir_hold_valid", {28'd0, out_valid}, 32'b0100);
        out_ready = 4'b0100;
        #1;
        chk("dir_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("dir_reload_data2", out_data2, 32'h22222222);
        chk("dir_reload_valid", {28'd0, out_valid}, 32'b0100);
        in_valid = 1'b0;
        tick();
        chk("dir_drained", {28'd0, out_valid}, 32'h0);
        chk("dir_rr_unchanged", {30'd0, rr_ptr}, 32'd0);

        // Round-robin streaming with wrap
        in_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 32'hA0 + k;
            #1;
            chk($sformatf("rr_ptr_%0d", k), {30'd0, rr_ptr}, k % 4);
            chk($sformatf("rr_ready_%0d", k), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("rr_valid_%0d", k), {28'd0, out_valid}, 32'd1 << (k % 4));
            chk($sformatf("rr_data_%0d", k), lane_data(k % 4), 32'hA0 + k);
        end
        chk("rr_ptr_after", {30'd0, rr_ptr}, 32'd2);
        in_valid = 1'b0;
        tick();
        chk("rr_drained", {28'd0, out_valid}, 32'h0);

        // Walk the pointer to 1 with lanes draining
        in_valid = 1'b1;
        in_data = 32'hC2; tick();
        in_data = 32'hC3; tick();
        in_data = 32'hC0; tick();
        in_valid = 1'b0;
        tick();
        chk("walk_rr_ptr", {30'd0, rr_ptr}, 32'd1);
        chk("walk_empty", {28'd0, out_valid}, 32'h0);

        // Strict round-robin stall on a full lane 1
        out_ready = 4'b0000; in_mode = 1'b0; in_sel = 2'd1;
        in_valid = 1'b1; in_data = 32'hB1;
        tick();
        in_mode = 1'b1; in_data = 32'hD1;
        #1;
        chk("strict_ready", {31'd0, in_ready}, 32'd0);
        chk("strict_valid", {28'd0, out_valid}, 32'b0010);
        tick(); tick();
        chk("strict_rr_hold", {30'd0, rr_ptr}, 32'd1);
        chk("strict_data1", out_data1, 32'hB1);
        chk("strict_lane_only", {28'd0, out_valid}, 32'b0010);
        out_ready = 4'b0010;
        #1;
        chk("strict_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk("strict_rr_adv", {30'd0, rr_ptr}, 32'd2);
        chk("strict_new_data1", out_data1, 32'hD1);
        chk("strict_valid_after", {28'd0, out_valid}, 32'b0010);

        // Simultaneous drain and load on lane 3
        out_ready = 4'b0000; in_mode = 1'b0; in_sel = 2'd3; in_data = 32'h5;
        tick();
        chk("sim_load_valid", {28'd0, out_valid}, 32'b1010);
        chk("sim_load_data3", out_data3, 32'h5);
        in_data = 32'h6; out_ready = 4'b1000;
        #1;
        chk("sim_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sim_valid", {28'd0, out_valid}, 32'b1010);
        chk("sim_data3", out_data3, 32'h6);
        chk("sim_rr", {30'd0, rr_ptr}, 32'd2);

        // Reset mid-operation
        out_ready = 4'b0000; in_sel = 2'd0; in_data = 32'h77;
        tick();
        chk("mid_pre_valid", {28'd0, out_valid}, 32'b1011);
        in_sel = 2'd2; in_data = 32'hDEADBEEF; rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_valid", {28'd0, out_valid}, 32'h0);
        chk("mid_rr", {30'd0, rr_ptr}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_data2", out_data2, 32'h0);
        chk("mid_data0", out_data0, 32'h0);
        tick();
        chk("mid_after_valid", {28'd0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
